// File: rtl/sqrt_arbiter.sv
// Purpose: round-robin share of one fixed-point square-root unit among NUM_REQ requesters, one op in flight.
// Latency: accept -> sq_in_valid 1 cycle; sq_out_valid -> rsp_valid 1 cycle; timeout response TIMEOUT cycles after start.
// Backpressure: rsp_valid holds id/data/err stable until rsp_ready; no new grant until that handshake completes.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (shared with the root unit)
//   req_valid/data  per-requester operand; requester i uses req_data[i*DATA_W +: DATA_W]
//   req_ready       one-hot combinational accept strobe, only ever high in ARB
//   rsp_*           tagged result to the consumer; rsp_err marks a watchdog timeout
//   sq_*            handshake to the shared root unit
module sqrt_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         sq_n,
  output logic                      sq_in_valid,
  input  logic                      sq_ready,
  input  logic [DATA_W-1:0]         sq_out,
  input  logic                      sq_out_valid
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ARB, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] sq_n_q, sq_n_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W:0]     arb_sum;
  logic [ID_W-1:0]   arb_idx;
  logic [DATA_W-1:0] gnt_data;

  // Search upward from rr_ptr, wrapping; the first asserted request wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    arb_sum = '0;
    arb_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (arb_sum >= (ID_W+1)'(NUM_REQ)) begin
        arb_sum = arb_sum - (ID_W+1)'(NUM_REQ);
      end
      arb_idx = arb_sum[ID_W-1:0];
      if (!gnt_vld && req_valid[arb_idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = arb_idx;
      end
    end
  end

  assign gnt_data = req_data[int'(gnt_id)*DATA_W +: DATA_W];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    sq_n_d     = sq_n_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    wd_d       = wd_q;
    case (state_q)
      ARB: begin
        if (gnt_vld) begin
          sq_n_d   = gnt_data;
          rsp_id_d = gnt_id;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (sq_ready) begin
          wd_d    = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        wd_d = wd_q + WD_W'(1);
        // A result arriving on the final watchdog cycle still beats the timeout.
        if (sq_out_valid) begin
          rsp_data_d = sq_out;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
          state_d  = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      sq_n_q     <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      sq_n_q     <= sq_n_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      wd_q       <= wd_d;
    end
  end

  // Strobes are masked while rst is high so nothing is accepted or started
  // in a cycle whose state update is about to be discarded.
  assign req_ready   = (state_q == ARB && gnt_vld && !rst) ? (NUM_REQ'(1) << gnt_id) : '0;
  assign sq_in_valid = (state_q == ISSUE) && sq_ready && !rst;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign sq_n        = sq_n_q;

endmodule
